imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter                                                 |
// | Description : Two-port arbiter in front of a single-port instruction       |
// |               memory. A fetch port (read-only) and a loader port           |
// |               (read/write) share the memory through a three-state          |
// |               IDLE -> ACCESS -> RESP sequence. Ties are broken round-robin. |
// |               Fetches that return a HALT opcode freeze further fetch       |
// |               grants until a resume pulse.                                 |
// | Ports       : clk, reset          - clock, synchronous active-high reset   |
// |               f_req/f_addr        - fetch request and byte address         |
// |               l_req/l_we/l_addr/  - loader request, type, byte address     |
// |               l_wdata               and write data                         |
// |               resume              - pulse that clears f_halted             |
// |               mem_addr/mem_we/    - instruction memory bus; mem_rdata is   |
// |               mem_wdata/mem_rdata   combinational from mem_addr            |
// |               f_ack/f_err/f_rdata - fetch completion, misalign flag, data  |
// |               l_ack/l_err/l_rdata - loader completion, misalign flag, data |
// |               f_halted, busy      - halt status, state is not IDLE         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [7:0]  f_addr,
   input  logic        l_req,
   input  logic        l_we,
   input  logic [7:0]  l_addr,
   input  logic [15:0] l_wdata,
   input  logic        resume,
   output logic [7:0]  mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        f_ack,
   output logic        f_err,
   output logic        l_ack,
   output logic        l_err,
   output logic [15:0] f_rdata,
   output logic [15:0] l_rdata,
   output logic        f_halted,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Port identifiers used for the winner and last-grant registers.
   localparam logic       c_PORT_FETCH  = 1'b0;
   localparam logic       c_PORT_LOADER = 1'b1;
   // Instruction bits [15:11] of the HALT opcode.
   localparam logic [4:0] c_HALT_OPCODE = 5'b00001;

   state_t      state_q,      state_d;
   logic        winner_q,     winner_d;
   logic        we_q,         we_d;
   logic        last_grant_q, last_grant_d;
   logic [7:0]  mem_addr_q,   mem_addr_d;
   logic        mem_we_q,     mem_we_d;
   logic [15:0] mem_wdata_q,  mem_wdata_d;
   logic        f_ack_q,      f_ack_d;
   logic        f_err_q,      f_err_d;
   logic        l_ack_q,      l_ack_d;
   logic        l_err_q,      l_err_d;
   logic [15:0] f_rdata_q,    f_rdata_d;
   logic [15:0] l_rdata_q,    l_rdata_d;
   logic        f_halted_q,   f_halted_d;
   logic        busy_q,       busy_d;

   logic        f_elig;
   logic        l_elig;
   logic        pick_loader;
   logic        misaligned;
   logic [15:0] access_data;
   logic        halt_set;

   // A halted fetch port is invisible to the arbiter; the loader always counts.
   assign f_elig = f_req & ~f_halted_q;
   assign l_elig = l_req;

   // On a tie the port that was not served last wins.
   always_comb begin
      pick_loader = 1'b0;
      if (f_elig && l_elig) begin
         pick_loader = (last_grant_q == c_PORT_FETCH);
      end else begin
         pick_loader = l_elig;
      end
   end

   // During ACCESS mem_addr_q/mem_wdata_q hold the latched request, so they
   // double as the latched address and write data.
   assign misaligned = (mem_addr_q[1:0] != 2'b00);

   always_comb begin
      access_data = mem_rdata;
      if (misaligned) begin
         access_data = 16'h0000;
      end else if (we_q) begin
         access_data = mem_wdata_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      we_d         = we_q;
      last_grant_d = last_grant_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      f_ack_d      = 1'b0;
      f_err_d      = 1'b0;
      l_ack_d      = 1'b0;
      l_err_d      = 1'b0;
      f_rdata_d    = f_rdata_q;
      l_rdata_d    = l_rdata_q;
      halt_set     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (f_elig || l_elig) begin
               state_d = ST_ACCESS;
               if (pick_loader) begin
                  winner_d    = c_PORT_LOADER;
                  we_d        = l_we;
                  mem_addr_d  = l_addr;
                  mem_wdata_d = l_wdata;
                  // Only aligned loader writes ever strobe the memory.
                  mem_we_d    = l_we & (l_addr[1:0] == 2'b00);
               end else begin
                  winner_d    = c_PORT_FETCH;
                  we_d        = 1'b0;
                  mem_addr_d  = f_addr;
               end
            end
         end

         ST_ACCESS: begin
            state_d      = ST_RESP;
            last_grant_d = winner_q;
            if (winner_q == c_PORT_LOADER) begin
               l_rdata_d = access_data;
               l_ack_d   = 1'b1;
               l_err_d   = misaligned;
            end else begin
               f_rdata_d = access_data;
               f_ack_d   = 1'b1;
               f_err_d   = misaligned;
               halt_set  = ~misaligned & (mem_rdata[15:11] == c_HALT_OPCODE);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Halt detection takes priority over a coincident resume pulse.
   always_comb begin
      f_halted_d = f_halted_q;
      if (halt_set) begin
         f_halted_d = 1'b1;
      end else if (resume) begin
         f_halted_d = 1'b0;
      end
   end

   assign busy_d = (state_d != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         winner_q     <= c_PORT_FETCH;
         we_q         <= 1'b0;
         last_grant_q <= c_PORT_LOADER;
         mem_addr_q   <= 8'h00;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 16'h0000;
         f_ack_q      <= 1'b0;
         f_err_q      <= 1'b0;
         l_ack_q      <= 1'b0;
         l_err_q      <= 1'b0;
         f_rdata_q    <= 16'h0000;
         l_rdata_q    <= 16'h0000;
         f_halted_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         we_q         <= we_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         f_ack_q      <= f_ack_d;
         f_err_q      <= f_err_d;
         l_ack_q      <= l_ack_d;
         l_err_q      <= l_err_d;
         f_rdata_q    <= f_rdata_d;
         l_rdata_q    <= l_rdata_d;
         f_halted_q   <= f_halted_d;
         busy_q       <= busy_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign f_ack     = f_ack_q;
   assign f_err     = f_err_q;
   assign l_ack     = l_ack_q;
   assign l_err     = l_err_q;
   assign f_rdata   = f_rdata_q;
   assign l_rdata   = l_rdata_q;
   assign f_halted  = f_halted_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_arbiter                                              |
// | Description : Self-checking bench for imem_arbiter with a behavioural      |
// |               memory and a transaction-level reference model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req;
   logic [7:0]  f_addr;
   logic        l_req;
   logic        l_we;
   logic [7:0]  l_addr;
   logic [15:0] l_wdata;
   logic        resume;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        f_ack;
   logic        f_err;
   logic        l_ack;
   logic        l_err;
   logic [15:0] f_rdata;
   logic [15:0] l_rdata;
   logic        f_halted;
   logic        busy;

   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .l_req     (l_req),
      .l_we      (l_we),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .resume    (resume),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .f_ack     (f_ack),
      .f_err     (f_err),
      .l_ack     (l_ack),
      .l_err     (l_err),
      .f_rdata   (f_rdata),
      .l_rdata   (l_rdata),
      .f_halted  (f_halted),
      .busy      (busy)
   );

   // Instruction memory: combinational read, write on the clock edge.
   logic [15:0] mem [256];
   logic        tb_we;
   logic [7:0]  tb_waddr;
   logic [15:0] tb_wdata;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      else if (tb_we)      mem[tb_waddr] <= tb_wdata;
   end

   // Reference model state.
   logic [15:0] ref_mem [256];
   logic        model_last_l;
   logic        model_halted;

   int errors = 0;
   int checks = 0;

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      tb_we    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      next_cycle();
      tb_we    = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic apply_reset();
      f_req  = 1'b0;
      l_req  = 1'b0;
      resume = 1'b0;
      reset  = 1'b1;
      next_cycle();
      next_cycle();
      reset  = 1'b0;
      model_last_l = 1'b1;
      model_halted = 1'b0;
   endtask

   // One served access, computed from the functional rules.
   task automatic model_serve(input logic port_l, input logic [7:0] a,
                              input logic we, input logic [15:0] wd,
                              output logic [15:0] data, output logic err);
      err = (a % 4) != 0;
      if (err)              data = 16'h0000;
      else if (port_l && we) data = wd;
      else                  data = ref_mem[a];
      if (port_l && we && !err) ref_mem[a] = wd;
      if (!port_l && !err && (data >> 11) == 16'd1) model_halted = 1'b1;
      model_last_l = port_l;
   endtask

   task automatic test_reset();
      checks++;
      if ({f_ack, f_err, l_ack, l_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_acks: got %b expected 0000", {f_ack, f_err, l_ack, l_err});
      end
      checks++;
      if ({f_rdata, l_rdata} !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h expected 0", {f_rdata, l_rdata});
      end
      checks++;
      if ({mem_addr, mem_we, mem_wdata} !== 25'h0) begin
         errors++; $display("FAIL reset_membus: got %h expected 0", {mem_addr, mem_we, mem_wdata});
      end
      checks++;
      if ({f_halted, busy} !== 2'b00) begin
         errors++; $display("FAIL reset_status: got %b expected 00", {f_halted, busy});
      end
      reset = 1'b0;
      model_last_l = 1'b1;
      model_halted = 1'b0;
   endtask

   task automatic test_loader_write();
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'd4; l_wdata = 16'h48CC;
      next_cycle();
      checks++;
      if ({mem_we, mem_addr, mem_wdata, busy, l_ack} !== {1'b1, 8'd4, 16'h48CC, 1'b1, 1'b0}) begin
         errors++; $display("FAIL lw_access: we/addr/wdata/busy/ack got %b/%0d/%h/%b/%b expected 1/4/48cc/1/0",
                            mem_we, mem_addr, mem_wdata, busy, l_ack);
      end
      // Payload changes while busy must not leak into the access.
      l_wdata = 16'hFFFF; l_addr = 8'd9;
      next_cycle();
      checks++;
      if ({l_ack, l_err, l_rdata, mem_we, f_ack} !== {1'b1, 1'b0, 16'h48CC, 1'b0, 1'b0}) begin
         errors++; $display("FAIL lw_resp: ack/err/rdata/we/f_ack got %b/%b/%h/%b/%b expected 1/0/48cc/0/0",
                            l_ack, l_err, l_rdata, mem_we, f_ack);
      end
      l_req = 1'b0;
      ref_mem[4] = 16'h48CC;
      next_cycle();
      checks++;
      if ({l_ack, busy, mem[4]} !== {1'b0, 1'b0, 16'h48CC}) begin
         errors++; $display("FAIL lw_done: ack/busy/mem4 got %b/%b/%h expected 0/0/48cc", l_ack, busy, mem[4]);
      end
   endtask

   task automatic test_fetch_read();
      preload(8'd8, 16'h4AFF);
      f_addr = 8'd8; f_req = 1'b1;
      next_cycle();
      checks++;
      if ({f_ack, mem_we, mem_addr} !== {1'b0, 1'b0, 8'd8}) begin
         errors++; $display("FAIL fr_access: ack/we/addr got %b/%b/%0d expected 0/0/8", f_ack, mem_we, mem_addr);
      end
      next_cycle();
      checks++;
      if ({f_ack, f_err, f_rdata, mem_we, f_halted, l_rdata} !== {1'b1, 1'b0, 16'h4AFF, 1'b0, 1'b0, 16'h48CC}) begin
         errors++; $display("FAIL fr_resp: ack/err/rdata/we/halt/l_rdata got %b/%b/%h/%b/%b/%h expected 1/0/4aff/0/0/48cc",
                            f_ack, f_err, f_rdata, mem_we, f_halted, l_rdata);
      end
      f_req = 1'b0;
      next_cycle();
      checks++;
      if (f_ack !== 1'b0) begin
         errors++; $display("FAIL fr_single_ack: got %b expected 0", f_ack);
      end
   endtask

   task automatic test_misaligned();
      logic [15:0] old6;
      old6 = ref_mem[6];
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'd6; l_wdata = 16'hBEEF;
      next_cycle();
      checks++;
      if (mem_we !== 1'b0) begin
         errors++; $display("FAIL mis_we: got %b expected 0", mem_we);
      end
      next_cycle();
      checks++;
      if ({l_ack, l_err, l_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
         errors++; $display("FAIL mis_resp: ack/err/rdata got %b/%b/%h expected 1/1/0000", l_ack, l_err, l_rdata);
      end
      l_req = 1'b0;
      next_cycle();
      checks++;
      if (mem[6] !== old6) begin
         errors++; $display("FAIL mis_mem: got %h expected %h", mem[6], old6);
      end
      f_addr = 8'd3; f_req = 1'b1;
      next_cycle();
      next_cycle();
      checks++;
      if ({f_ack, f_err, f_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
         errors++; $display("FAIL mis_fetch: ack/err/rdata got %b/%b/%h expected 1/1/0000", f_ack, f_err, f_rdata);
      end
      f_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic exp_f;
      logic exp_l;
      apply_reset();
      preload(8'd20, 16'h1234);
      preload(8'd24, 16'h5678);
      f_addr = 8'd20; l_addr = 8'd24; l_we = 1'b0;
      f_req = 1'b1; l_req = 1'b1;
      // Fetch wins the first tie after reset, then grants alternate.
      for (int i = 1; i <= 12; i++) begin
         next_cycle();
         exp_f = (i == 2) || (i == 8);
         exp_l = (i == 5) || (i == 11);
         checks++;
         if ({f_ack, l_ack} !== {exp_f, exp_l}) begin
            errors++; $display("FAIL b2b_cycle%0d: f_ack/l_ack got %b%b expected %b%b", i, f_ack, l_ack, exp_f, exp_l);
         end
      end
      f_req = 1'b0; l_req = 1'b0;
      checks++;
      if ({f_rdata, l_rdata} !== {16'h1234, 16'h5678}) begin
         errors++; $display("FAIL b2b_data: got %h/%h expected 1234/5678", f_rdata, l_rdata);
      end
      next_cycle();
      model_last_l = 1'b1;
   endtask

   task automatic test_halt();
      int  f_acks;
      bit  got_l;
      bit  got_f;
      preload(8'd88, 16'h0800);
      preload(8'd12, 16'h3C3C);
      preload(8'd0,  16'h2222);
      f_addr = 8'd88; f_req = 1'b1;
      next_cycle();
      next_cycle();
      checks++;
      if ({f_ack, f_rdata, f_halted} !== {1'b1, 16'h0800, 1'b1}) begin
         errors++; $display("FAIL halt_set: ack/rdata/halted got %b/%h/%b expected 1/0800/1", f_ack, f_rdata, f_halted);
      end
      f_req = 1'b0;
      next_cycle();
      f_addr = 8'd12; f_req = 1'b1;
      l_addr = 8'd0; l_we = 1'b0; l_req = 1'b1;
      f_acks = 0; got_l = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         if (f_ack === 1'b1) f_acks++;
         if (l_ack === 1'b1) begin
            got_l = 1'b1;
            l_req = 1'b0;
            checks++;
            if (l_rdata !== 16'h2222) begin
               errors++; $display("FAIL halt_loader_data: got %h expected 2222", l_rdata);
            end
         end
      end
      checks++;
      if ({got_l, f_acks[3:0], f_halted} !== {1'b1, 4'd0, 1'b1}) begin
         errors++; $display("FAIL halt_block: loader_done/f_acks/halted got %b/%0d/%b expected 1/0/1", got_l, f_acks, f_halted);
      end
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      checks++;
      if (f_halted !== 1'b0) begin
         errors++; $display("FAIL halt_resume: got %b expected 0", f_halted);
      end
      got_f = 1'b0;
      for (int i = 0; i < 6 && !got_f; i++) begin
         next_cycle();
         if (f_ack === 1'b1) begin
            got_f = 1'b1;
            f_req = 1'b0;
            checks++;
            if ({f_rdata, f_halted} !== {16'h3C3C, 1'b0}) begin
               errors++; $display("FAIL halt_refetch: rdata/halted got %h/%b expected 3c3c/0", f_rdata, f_halted);
            end
         end
      end
      checks++;
      if (!got_f) begin
         errors++; $display("FAIL halt_refetch_timeout: got no f_ack expected f_ack");
      end
      next_cycle();
      // Resume on the same edge that detects HALT: halt must stick.
      f_addr = 8'd88; f_req = 1'b1;
      next_cycle();
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      f_req = 1'b0;
      checks++;
      if ({f_ack, f_halted} !== 2'b11) begin
         errors++; $display("FAIL halt_vs_resume: ack/halted got %b/%b expected 1/1", f_ack, f_halted);
      end
      next_cycle();
      resume = 1'b1;
      next_cycle();
      resume = 1'b0;
      model_halted = 1'b0;
      model_last_l = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      bit seen_ack;
      f_addr = 8'd88; f_req = 1'b1;
      next_cycle();
      next_cycle();
      f_req = 1'b0;
      checks++;
      if (f_halted !== 1'b1) begin
         errors++; $display("FAIL rst_pre_halt: got %b expected 1", f_halted);
      end
      next_cycle();
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'd16; l_wdata = 16'hA5A5;
      next_cycle();
      checks++;
      if (mem_we !== 1'b1) begin
         errors++; $display("FAIL rst_pre_we: got %b expected 1", mem_we);
      end
      reset = 1'b1; l_req = 1'b0;
      next_cycle();
      reset = 1'b0;
      ref_mem[16] = 16'hA5A5;
      checks++;
      if ({mem_we, busy, f_halted, l_ack} !== 4'b0000) begin
         errors++; $display("FAIL rst_abort: we/busy/halted/ack got %b%b%b%b expected 0000", mem_we, busy, f_halted, l_ack);
      end
      seen_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (l_ack === 1'b1 || f_ack === 1'b1) seen_ack = 1'b1;
      end
      checks++;
      if (seen_ack) begin
         errors++; $display("FAIL rst_no_ack: got an ack expected none");
      end
      model_last_l = 1'b1;
      model_halted = 1'b0;
   endtask

   task automatic test_random();
      logic        fr, lr, lwe, first_l, nxt_l;
      logic [7:0]  fa, la;
      logic [15:0] lwd;
      logic        exp_port [2];
      logic [15:0] exp_data [2];
      logic        exp_err  [2];
      logic        exp_halt [2];
      int          n, idx;
      apply_reset();
      for (int r = 0; r < 60; r++) begin
         if (model_halted) begin
            resume = 1'b1;
            next_cycle();
            resume = 1'b0;
            model_halted = 1'b0;
            checks++;
            if (f_halted !== 1'b0) begin
               errors++; $display("FAIL rnd_resume r%0d: got %b expected 0", r, f_halted);
            end
         end
         do begin
            fr = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
         end while (!fr && !lr);
         fa = 8'($urandom_range(0, 31));
         la = 8'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) fa[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) la[1:0] = 2'b00;
         lwe = 1'($urandom_range(0, 1));
         lwd = 16'($urandom);
         if ($urandom_range(0, 5) == 0) lwd[15:11] = 5'b00001;
         first_l = (fr && lr) ? !model_last_l : lr;
         n = 0;
         for (int k = 0; k < 2; k++) begin
            nxt_l = (k == 0) ? first_l : !first_l;
            if ((k == 0) || (fr && lr)) begin
               model_serve(nxt_l, nxt_l ? la : fa, lwe, lwd, exp_data[n], exp_err[n]);
               exp_port[n] = nxt_l;
               exp_halt[n] = model_halted;
               n++;
            end
         end
         f_addr = fa; f_req = fr;
         l_addr = la; l_we = lwe; l_wdata = lwd; l_req = lr;
         idx = 0;
         for (int cyc = 1; cyc <= 12 && idx < n; cyc++) begin
            next_cycle();
            if (f_ack === 1'b1 || l_ack === 1'b1) begin
               checks++;
               if ({f_ack, l_ack} !== (exp_port[idx] ? 2'b01 : 2'b10) || cyc != 3 * idx + 2) begin
                  errors++; $display("FAIL rnd_order r%0d: f_ack/l_ack %b%b at cycle %0d expected port_l=%b at cycle %0d",
                                     r, f_ack, l_ack, cyc, exp_port[idx], 3 * idx + 2);
               end
               checks++;
               if (exp_port[idx]) begin
                  if ({l_rdata, l_err} !== {exp_data[idx], exp_err[idx]}) begin
                     errors++; $display("FAIL rnd_l_data r%0d: rdata/err got %h/%b expected %h/%b",
                                        r, l_rdata, l_err, exp_data[idx], exp_err[idx]);
                  end
                  l_req = 1'b0;
               end else begin
                  if ({f_rdata, f_err} !== {exp_data[idx], exp_err[idx]}) begin
                     errors++; $display("FAIL rnd_f_data r%0d: rdata/err got %h/%b expected %h/%b",
                                        r, f_rdata, f_err, exp_data[idx], exp_err[idx]);
                  end
                  f_req = 1'b0;
               end
               checks++;
               if (f_halted !== exp_halt[idx]) begin
                  errors++; $display("FAIL rnd_halt r%0d: got %b expected %b", r, f_halted, exp_halt[idx]);
               end
               idx++;
            end
         end
         checks++;
         if (idx != n) begin
            errors++; $display("FAIL rnd_timeout r%0d: got %0d acks expected %0d", r, idx, n);
         end
         f_req = 1'b0; l_req = 1'b0;
         next_cycle();
      end
   endtask

   initial begin
      reset = 1'b1; f_req = 1'b0; f_addr = 8'h00;
      l_req = 1'b0; l_we = 1'b0; l_addr = 8'h00; l_wdata = 16'h0000;
      resume = 1'b0; tb_we = 1'b0; tb_waddr = 8'h00; tb_wdata = 16'h0000;
      @(negedge clk);
      for (int a = 0; a < 256; a++) preload(8'(a), 16'($urandom));
      test_reset();
      test_loader_write();
      test_fetch_read();
      test_misaligned();
      test_back_to_back();
      test_halt();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
